// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run / step / breakpoint sequencer for CPU_pipe on the debug board.
//   The VIO command levels are synchronised and edge-detected. The resulting
//   pulses move the CPU through RESET, HALT, free-running RUN and N-cycle STEP.
//
// Ports
//   clk         free-running board clock; all logic is on the rising edge
//   rst         asynchronous, active-low reset
//   cmd_run     async level; a rising edge is a run command
//   cmd_step    async level; a rising edge is a step command
//   cmd_halt    async level; a rising edge is a halt command
//   cmd_reset   async level; a rising edge is a CPU reset command
//   bp_en       breakpoint enable (quasi-static)
//   bp_addr     breakpoint pc (quasi-static)
//   step_count  enabled cycles per step command; 0 is treated as 1
//   pc          current pc from CPU_pipe
//   cpu_ce      CPU clock enable (feeds the BUFGCE for clkm)
//   cpu_rst     active-high CPU reset, registered
//   state       RESET=00, HALT=01, RUN=10, STEP=11
//   halted      high iff state==HALT
//   bp_hit      sticky: the last stop was caused by the breakpoint
//   cycle_cnt   number of cycles with cpu_ce=1, wraps
module cpu_run_ctrl #(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 4,
    parameter int STEP_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_halt,
    input  logic              cmd_reset,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    input  logic [STEP_W-1:0] step_count,
    input  logic [31:0]       pc,
    output logic              cpu_ce,
    output logic              cpu_rst,
    output logic [1:0]        state,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
    localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES);

    typedef enum logic [1:0] {
        S_RESET = 2'b00,
        S_HALT  = 2'b01,
        S_RUN   = 2'b10,
        S_STEP  = 2'b11
    } state_t;

    state_t            st;
    logic [RC_W-1:0]   rcnt;
    logic [STEP_W-1:0] sleft;
    logic              mask;

    // Command vector layout: {reset, halt, step, run}.
    // sync1/sync2 form the synchroniser and sync_d is the edge register.
    logic [3:0] sync1, sync2, sync_d, pulse;
    logic       p_run, p_step, p_halt, p_reset;
    logic       active, bp_fire;

    assign pulse   = sync2 & ~sync_d;
    assign p_run   = pulse[0];
    assign p_step  = pulse[1];
    assign p_halt  = pulse[2];
    assign p_reset = pulse[3];

    assign state  = st;
    assign halted = (st == S_HALT);

    // RUN and STEP both have state[1] set. The breakpoint gates the clock in
    // the same cycle, so the instruction at bp_addr is never clocked. The
    // resume mask lets the first cycle after a resume pass a matching pc.
    always_comb begin
        active  = st[1];
        bp_fire = active & bp_en & (pc == bp_addr) & ~mask;
        cpu_ce  = active & ~bp_fire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_d    <= '0;
            st        <= S_RESET;
            cpu_rst   <= 1'b1;
            rcnt      <= RC_LOAD;
            sleft     <= '0;
            mask      <= 1'b0;
            bp_hit    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            sync1  <= {cmd_reset, cmd_halt, cmd_step, cmd_run};
            sync2  <= sync1;
            sync_d <= sync2;

            case (st)
                S_RESET: begin
                    cycle_cnt <= '0;
                    bp_hit    <= 1'b0;
                    if (p_reset) begin
                        rcnt <= RC_LOAD;
                    end else if (rcnt == RC_W'(1)) begin
                        st      <= S_HALT;
                        cpu_rst <= 1'b0;
                    end else begin
                        rcnt <= rcnt - RC_W'(1);
                    end
                end

                S_HALT: begin
                    if (p_reset) begin
                        st        <= S_RESET;
                        cpu_rst   <= 1'b1;
                        rcnt      <= RC_LOAD;
                        cycle_cnt <= '0;
                        bp_hit    <= 1'b0;
                        mask      <= 1'b0;
                    end else if (p_run) begin
                        st     <= S_RUN;
                        mask   <= 1'b1;
                        bp_hit <= 1'b0;
                    end else if (p_step) begin
                        st     <= S_STEP;
                        mask   <= 1'b1;
                        bp_hit <= 1'b0;
                        sleft  <= (step_count == '0) ? STEP_W'(1) : step_count;
                    end
                end

                default: begin  // S_RUN, S_STEP
                    if (cpu_ce) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                        mask      <= 1'b0;
                        if (st == S_STEP)
                            sleft <= sleft - STEP_W'(1);
                    end
                    // The later assignments below override the counter update
                    // above when a reset aborts the run.
                    if (p_reset) begin
                        st        <= S_RESET;
                        cpu_rst   <= 1'b1;
                        rcnt      <= RC_LOAD;
                        cycle_cnt <= '0;
                        bp_hit    <= 1'b0;
                        mask      <= 1'b0;
                    end else if (p_halt) begin
                        st <= S_HALT;
                    end else if (bp_fire) begin
                        st     <= S_HALT;
                        bp_hit <= 1'b1;
                    end else if ((st == S_STEP) && cpu_ce && (sleft == STEP_W'(1))) begin
                        st <= S_HALT;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int CNT_W  = 8;
    localparam int RSTC   = 4;
    localparam int STEP_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_run = 0, cmd_step = 0, cmd_halt = 0, cmd_reset = 0;
    logic              bp_en = 0;
    logic [31:0]       bp_addr = '0;
    logic [STEP_W-1:0] step_count = '0;
    logic [31:0]       pc = '0;
    logic              cpu_ce, cpu_rst, halted, bp_hit;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;

    cpu_run_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(RSTC), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_reset(cmd_reset),
        .bp_en(bp_en), .bp_addr(bp_addr), .step_count(step_count), .pc(pc),
        .cpu_ce(cpu_ce), .cpu_rst(cpu_rst), .state(state), .halted(halted),
        .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- CPU emulation: pc advances by 4 per enabled cycle ----
    logic ce_q = 0, rs_q = 1;
    always @(negedge clk) begin
        ce_q = cpu_ce;
        rs_q = cpu_rst;
    end
    always @(posedge clk) begin
        #1;
        if (rs_q) pc = '0;
        else if (ce_q) pc = (pc + 32'd4) & 32'hFF;
    end

    // ---------------- reference model -------------------------------------
    // Modes: 0 reset, 1 halted, 2 running, 3 stepping.
    int       m_mode;
    int       m_rst_left, m_steps_left, m_cnt;
    bit       m_resume, m_hit;
    bit [2:0] hist [4];   // per command: sampled levels, bit0 newest

    function automatic bit model_ce();
        bit running;
        running = (m_mode == 2) || (m_mode == 3);
        return running && !(bp_en && pc == bp_addr && !m_resume);
    endfunction

    task automatic model_init();
        m_mode = 0; m_rst_left = RSTC; m_steps_left = 0; m_cnt = 0;
        m_resume = 0; m_hit = 0;
        for (int c = 0; c < 4; c++) hist[c] = '0;
    endtask

    task automatic enter_reset();
        m_mode = 0; m_rst_left = RSTC; m_cnt = 0; m_hit = 0; m_resume = 0;
    endtask

    initial model_init();

    always @(posedge clk or negedge rst) begin
        bit lv [4];
        bit pr, ps, ph, px, ce, match;
        if (!rst) begin
            model_init();
        end else begin
            lv[0] = cmd_run; lv[1] = cmd_step; lv[2] = cmd_halt; lv[3] = cmd_reset;
            // A command acts on the third edge after its level is first sampled high.
            pr = hist[0][1] & ~hist[0][2];
            ps = hist[1][1] & ~hist[1][2];
            ph = hist[2][1] & ~hist[2][2];
            px = hist[3][1] & ~hist[3][2];
            for (int c = 0; c < 4; c++) hist[c] = {hist[c][1:0], lv[c]};
            ce    = model_ce();
            match = (m_mode >= 2) && !ce;
            case (m_mode)
                0: begin
                    m_cnt = 0;
                    if (px) m_rst_left = RSTC;
                    else if (m_rst_left == 1) m_mode = 1;
                    else m_rst_left--;
                end
                1: begin
                    if (px) enter_reset();
                    else if (pr) begin m_mode = 2; m_resume = 1; m_hit = 0; end
                    else if (ps) begin
                        m_mode = 3; m_resume = 1; m_hit = 0;
                        m_steps_left = (step_count == 0) ? 1 : int'(step_count);
                    end
                end
                default: begin
                    bit last;
                    last = 0;
                    if (ce) begin
                        m_cnt = (m_cnt + 1) % (1 << CNT_W);
                        m_resume = 0;
                        if (m_mode == 3) begin
                            m_steps_left--;
                            last = (m_steps_left == 0);
                        end
                    end
                    if (px) enter_reset();
                    else if (ph) m_mode = 1;
                    else if (match) begin m_mode = 1; m_hit = 1; end
                    else if (last) m_mode = 1;
                end
            endcase
        end
    end

    // ---------------- scoreboard ------------------------------------------
    typedef struct {
        bit ce;
        bit rs;
        int st;
        bit hit;
        int cnt;
    } exp_t;
    exp_t q[$];

    always @(negedge clk) begin
        exp_t e;
        e.ce  = model_ce();
        e.rs  = (m_mode == 0);
        e.st  = m_mode;
        e.hit = m_hit;
        e.cnt = m_cnt;
        q.push_back(e);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cpu_ce",    int'(cpu_ce),    int'(e.ce));
            chk("cpu_rst",   int'(cpu_rst),   int'(e.rs));
            chk("state",     int'(state),     e.st);
            chk("halted",    int'(halted),    int'(e.st == 1));
            chk("bp_hit",    int'(bp_hit),    int'(e.hit));
            chk("cycle_cnt", int'(cycle_cnt), e.cnt);
        end
    end

    // ---------------- stimulus --------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int idx, input bit v);
        case (idx)
            0: cmd_run = v;
            1: cmd_step = v;
            2: cmd_halt = v;
            default: cmd_reset = v;
        endcase
    endtask

    task automatic pulse_cmd(input int idx);
        set_cmd(idx, 1'b1);
        cyc(4);
        set_cmd(idx, 1'b0);
        cyc(2);
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;                       // release away from an edge
        cyc(8);                           // RESET for RSTC cycles, then HALT

        step_count = 3;  pulse_cmd(1); cyc(6);
        step_count = 0;  pulse_cmd(1); cyc(6);

        bp_en = 1; bp_addr = 32'h20;
        pulse_cmd(0); cyc(12);            // stops at pc 0x20
        pulse_cmd(0); cyc(6);             // resumes past 0x20
        pulse_cmd(2); cyc(3);

        pulse_cmd(0); cyc(3);             // halt and reset together in RUN
        cmd_halt = 1; cmd_reset = 1; cyc(4);
        cmd_halt = 0; cmd_reset = 0; cyc(8);

        bp_en = 0;
        cmd_run = 1; cyc(20);             // held level: a single run
        pulse_cmd(2); cyc(10);
        cmd_run = 0; cyc(3);

        pulse_cmd(0); cyc(300);           // cycle_cnt wraps
        pulse_cmd(2); cyc(3);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(15) == 0) cmd_run  = ~cmd_run;
            if ($urandom_range(15) == 0) cmd_step = ~cmd_step;
            if ($urandom_range(23) == 0) cmd_halt = ~cmd_halt;
            if ($urandom_range(63) == 0) cmd_reset = ~cmd_reset;
            if ($urandom_range(7) == 0)  step_count = STEP_W'($urandom_range(4));
            if ($urandom_range(31) == 0) bp_en = ~bp_en;
            if ($urandom_range(31) == 0) bp_addr = 32'($urandom_range(63)) << 2;
            if ($urandom_range(599) == 0) begin
                rst = 1'b0; cyc(1); rst = 1'b1;
            end
            cyc(1);
        end
        cyc(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/breakpoint controller for CPU_pipe on the debug board.
- Replaces hand-toggling of the CPU clock and reset through VIO ASYNC_OUT.
- Takes asynchronous command levels from VIO, synchronises and edge-detects them, and sequences the CPU through reset, halt, free-run and N-cycle step.
- Outputs a clock enable (drives BUFGCE for clkm), an active-high CPU reset, a cycle counter and a pc-match breakpoint.

Parameters:
- CNT_W, 32: width of cycle_cnt.
- RST_CYCLES, 4: cycles cpu_rst is held after any reset entry; must be ≥1.
- STEP_W, 16: width of step_count.

Ports:
- clk  in  1  free-running board clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_run  in  1  async level from VIO; rising edge = run command.
- cmd_step  in  1  async level; rising edge = step command.
- cmd_halt  in  1  async level; rising edge = halt command.
- cmd_reset  in  1  async level; rising edge = CPU reset command.
- bp_en  in  1  breakpoint enable; quasi-static.
- bp_addr  in  32  breakpoint pc; quasi-static.
- step_count  in  STEP_W  cycles per step command; 0 treated as 1.
- pc  in  32  current pc from CPU_pipe.
- cpu_ce  out  1  CPU clock enable; combinational from registered state, pc and bp inputs.
- cpu_rst  out  1  active-high reset to CPU_pipe; registered.
- state  out  2  RESET=00, HALT=01, RUN=10, STEP=11.
- halted  out  1  high iff state==HALT.
- bp_hit  out  1  sticky; last stop was caused by the breakpoint.
- cycle_cnt  out  CNT_W  number of cycles with cpu_ce=1.

Behaviour:
- Reset (rst=0, async):
  - state=RESET, cpu_rst=1, cpu_ce=0, bp_hit=0, cycle_cnt=0, halted=0.
  - Sync flops cleared, rcnt=RST_CYCLES.
- Commands:
  - Each cmd_* passes a 2-flop synchroniser plus an edge register.
  - A one-cycle internal pulse occurs 3 clk edges after the input rises.
  - Holding the level high produces no repeat pulse.
- Priority on the same cycle: reset > halt > breakpoint > run > step.
- RESET:
  - cpu_rst=1, cpu_ce=0, rcnt decrements each cycle.
  - When rcnt reaches 1, next state is HALT and cpu_rst=0 next cycle, giving exactly RST_CYCLES cycles of cpu_rst=1.
  - On entry, cycle_cnt is cleared and bp_hit is cleared.
- HALT:
  - cpu_ce=0.
  - Run pulse → RUN.
  - Step pulse → STEP, with sleft=max(step_count,1) latched.
  - Reset pulse → RESET, with rcnt reloaded.
  - Halt pulse has no effect.
  - Any accepted run or step clears bp_hit.
- RUN:
  - cpu_ce=1 unless the breakpoint fires.
  - Breakpoint fires when bp_en=1 and pc==bp_addr and mask=0. Then cpu_ce=0 that same cycle (instruction at bp_addr not clocked), next state HALT, bp_hit←1.
  - Halt pulse → HALT; cpu_ce stays 1 during the pulse cycle.
  - Run and step pulses are ignored.
- STEP:
  - Same cpu_ce and breakpoint rules as RUN.
  - sleft decrements on every cycle with cpu_ce=1.
  - When sleft==1 and cpu_ce=1 → HALT; exactly step_count (min 1) enabled cycles per step.
  - Halt or breakpoint ends the step early.
  - Run and step pulses are ignored.
- Resume mask:
  - mask is set on every HALT→RUN or HALT→STEP transition.
  - It is cleared after the first cycle with cpu_ce=1.
  - Resuming while pc==bp_addr therefore executes past the breakpoint instead of deadlocking.
- cycle_cnt:
  - Increments on each cycle with cpu_ce=1 and wraps modulo 2^CNT_W.
  - Cleared only in RESET.
- A reset pulse in RUN or STEP aborts immediately: next cycle state=RESET, cpu_rst=1, cpu_ce=0.
- Changing bp_addr or bp_en while running takes effect the same cycle (combinational compare).

Test Plan:
- Release rst, RST_CYCLES=4 → cpu_rst=1 for exactly 4 clk, then state=01, cpu_ce=0, cycle_cnt=0.
- In HALT, set step_count=3, raise cmd_step → cpu_ce=1 for exactly 3 cycles starting 3 cycles after the edge, then HALT, cycle_cnt=3. Repeat with step_count=0 → 1 cycle, cycle_cnt=4.
- Set bp_en=1, bp_addr=0x20, run with pc stepping by 4 from 0 → cpu_ce=0 in the cycle pc==0x20, state=HALT, bp_hit=1. Run again → pc advances past 0x20 with no immediate re-halt, and bp_hit=0.
- In RUN, raise cmd_halt and cmd_reset together → state=RESET, cpu_rst=1, cycle_cnt=0. Reset wins.
- Hold cmd_run high for 20 cycles, then issue halt → a single transition to RUN and no restart after the halt. Preload cycle_cnt near 2^CNT_W-1 (CNT_W=8 build) and run → wraps 255→0.
